// File: rtl/mem_bist_if.sv
// Request/response bundle between the BIST initiator and the dual-port memory.
// The master drives the write and read requests. The slave returns read data and port-idle flags.
interface mem_bist_if #(
    parameter int WORD_SIZE    = 8,
    parameter int ADDRESS_SIZE = 4
);
    logic                    w_en;
    logic [ADDRESS_SIZE-1:0] w_addr;
    logic [WORD_SIZE-1:0]    w_data;
    logic                    r_en;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0]    r_data;
    logic                    r_ready;
    logic                    w_ready;

    modport master (
        output w_en, w_addr, w_data, r_en, r_addr,
        input  r_data, r_ready, w_ready
    );

    modport slave (
        input  w_en, w_addr, w_data, r_en, r_addr,
        output r_data, r_ready, w_ready
    );
endinterface

// File: rtl/mem_bist.sv
// Memory BIST initiator: runs five ascending sweeps (init check, P write/verify, ~P write/verify).
// Latency: each word costs an issue cycle plus the port's busy time; done rises 241 cycles after start (16 words, zero waits).
// Backpressure: stalls on w_ready/r_ready low; a watchdog aborts the run if a port stays busy too long.
module mem_bist #(
    parameter int                    WORD_SIZE    = 8,
    parameter logic [WORD_SIZE-1:0]  WORD_INIT    = 8'b0,
    parameter int                    ADDRESS_SIZE = 4,
    parameter int                    MEMORY_QTY   = 16,
    parameter logic [WORD_SIZE-1:0]  SEED         = 8'hA5,
    parameter int                    ERR_SIZE     = 8,
    parameter int                    TIMEOUT_SIZE = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    mem_bist_if.master              mem,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [ERR_SIZE-1:0]     error_count,
    output logic [ADDRESS_SIZE-1:0] fail_addr
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_W_ISSUE, S_W_WAIT, S_R_ISSUE, S_R_WAIT, S_DONE
    } state_t;

    localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(MEMORY_QTY - 1);
    localparam logic [TIMEOUT_SIZE-1:0] WD_LAST   = {{(TIMEOUT_SIZE-1){1'b1}}, 1'b0};

    state_t                  state, state_next;
    logic [ADDRESS_SIZE-1:0] addr;
    logic [2:0]              phase, phase_next;
    logic [TIMEOUT_SIZE-1:0] wd;
    logic [WORD_SIZE-1:0]    pat, expected;
    logic                    waiting, wd_expired, hs_done, sweep_end, mismatch, launch, timeout_hit;

    always_comb begin
        pat        = SEED ^ WORD_SIZE'(addr);
        phase_next = phase + 3'd1;
        case (phase)
            3'd0:    expected = WORD_INIT;
            3'd2:    expected = pat;
            default: expected = ~pat;
        endcase
        waiting     = (state == S_WAIT_RDY) || (state == S_W_WAIT) || (state == S_R_WAIT);
        wd_expired  = waiting && (wd == WD_LAST);
        hs_done     = ((state == S_W_WAIT) && mem.w_ready) || ((state == S_R_WAIT) && mem.r_ready);
        sweep_end   = (addr == LAST_ADDR);
        mismatch    = (state == S_R_WAIT) && mem.r_ready && (mem.r_data != expected);
        launch      = ((state == S_IDLE) || (state == S_DONE)) && start;
        // Entering DONE without a completed handshake can only be the watchdog.
        timeout_hit = busy && (state_next == S_DONE) && !hs_done;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_next = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (mem.r_ready && mem.w_ready) state_next = phase[0] ? S_W_ISSUE : S_R_ISSUE;
                else if (wd_expired)            state_next = S_DONE;
            end
            S_W_ISSUE: state_next = S_W_WAIT;
            S_R_ISSUE: state_next = S_R_WAIT;
            S_W_WAIT, S_R_WAIT: begin
                if (hs_done) begin
                    if (!sweep_end)         state_next = (state == S_W_WAIT) ? S_W_ISSUE : S_R_ISSUE;
                    else if (phase == 3'd4) state_next = S_DONE;
                    else                    state_next = phase_next[0] ? S_W_ISSUE : S_R_ISSUE;
                end else if (wd_expired) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem.w_en   = (state == S_W_ISSUE);
        mem.r_en   = (state == S_R_ISSUE);
        mem.w_addr = addr;
        mem.r_addr = addr;
        busy       = (state != S_IDLE) && (state != S_DONE);
        // Gated by phase so the bus idles at zero outside the write sweeps.
        case (phase)
            3'd1:    mem.w_data = pat;
            3'd3:    mem.w_data = ~pat;
            default: mem.w_data = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr        <= '0;
            phase       <= '0;
            wd          <= '0;
            error_count <= '0;
            fail_addr   <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            if (state_next != state) wd <= '0;
            else if (waiting)        wd <= wd + 1'b1;

            if (launch) begin
                addr        <= '0;
                phase       <= '0;
                error_count <= '0;
                fail_addr   <= '0;
                done        <= 1'b0;
                pass        <= 1'b0;
                timeout     <= 1'b0;
            end else begin
                if (mismatch) begin
                    if (error_count != '1) error_count <= error_count + 1'b1;
                    if (error_count == '0) fail_addr   <= addr;
                end
                if (hs_done) begin
                    if (sweep_end) begin
                        addr  <= '0;
                        phase <= phase_next;
                    end else begin
                        addr  <= addr + 1'b1;
                    end
                end
                if (busy && (state_next == S_DONE)) begin
                    done    <= 1'b1;
                    timeout <= timeout_hit;
                    pass    <= !timeout_hit && (error_count == '0) && !mismatch;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_bist.sv
// Scoreboarded bench for mem_bist against a behavioural dual-port memory model.
// Stimulus queues expected run results; a negedge monitor checks them as done rises or reset asserts.
module tb_mem_bist;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass, timeout;
    logic [7:0] error_count;
    logic [3:0] fail_addr;

    mem_bist_if #(.WORD_SIZE(8), .ADDRESS_SIZE(4)) bus ();

    mem_bist dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .mem         (bus),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .error_count (error_count),
        .fail_addr   (fail_addr)
    );

    always #5 clock = ~clock;

    // Memory model: init busy for 4 cycles after reset, ready drops for 1+WAIT cycles after each request.
    int         ww = 0, rw = 0;
    bit         stuck = 0, hold_low = 0;
    logic [7:0] mem_arr [16];
    int         wcnt, rcnt;
    logic [7:0] rdat;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem_arr[i] <= 8'h00;
            wcnt <= 4;
            rcnt <= 4;
            rdat <= 8'h00;
        end else begin
            if (bus.w_en) begin
                mem_arr[bus.w_addr] <= (stuck && bus.w_addr == 4'd5) ? (bus.w_data & 8'hFE) : bus.w_data;
                wcnt <= 1 + ww;
            end else if (wcnt != 0) begin
                wcnt <= wcnt - 1;
            end
            if (bus.r_en) begin
                rdat <= mem_arr[bus.r_addr];
                rcnt <= 1 + rw;
            end else if (rcnt != 0) begin
                rcnt <= rcnt - 1;
            end
        end
    end

    assign bus.w_ready = (wcnt == 0);
    assign bus.r_ready = (rcnt == 0) && !hold_low;
    assign bus.r_data  = rdat;

    typedef struct {
        bit is_rst;
        int lat;
        bit ps;
        bit to;
        int err;
        int fa;
        int wn;
        int rn;
    } exp_t;

    exp_t sb[$];
    int   npass = 0, ntot = 0, nfail = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        ntot++;
        if (act === req) npass++;
        else begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor
    exp_t e;
    logic busy_q = 0, done_q = 0, wen_q = 0, ren_q = 0;
    int   t0 = 0, wn = 0, rn = 0, viol = 0, wait_cyc = 0;

    always @(negedge clock) begin
        if (reset) begin
            if (sb.size() != 0 && sb[0].is_rst) begin
                e = sb.pop_front();
                chk("reset_outputs_zero",
                    {30'd0, busy, done, pass, timeout, error_count, fail_addr,
                     bus.w_en, bus.r_en, bus.w_addr, bus.r_addr, bus.w_data}, 64'd0);
            end
            busy_q = 0; done_q = 0; wen_q = 0; ren_q = 0;
        end else begin
            if (busy && !busy_q) begin
                t0 = cyc; wn = 0; rn = 0; viol = 0;
                chk("run_start_cleared", {49'd0, error_count, fail_addr, done, pass, timeout}, 64'd0);
            end
            if (bus.w_en) wn++;
            if (bus.r_en) rn++;
            if ((bus.w_en && bus.r_en) || (bus.w_en && wen_q) || (bus.r_en && ren_q)) viol++;
            if (done && !done_q) begin
                if (sb.size() != 0 && !sb[0].is_rst) begin
                    e = sb.pop_front();
                    wait_cyc = 0;
                    chk("done_latency", cyc - t0, e.lat);
                    chk("pass",         pass, e.ps);
                    chk("timeout",      timeout, e.to);
                    chk("error_count",  error_count, e.err);
                    chk("fail_addr",    fail_addr, e.fa);
                    chk("w_en_pulses",  wn, e.wn);
                    chk("r_en_pulses",  rn, e.rn);
                    chk("en_protocol_violations", viol, 0);
                end else begin
                    chk("unexpected_done", done, 0);
                end
            end
            if (sb.size() != 0 && !sb[0].is_rst) begin
                wait_cyc++;
                if (wait_cyc > 1500) begin
                    chk("done_within_budget", wait_cyc, 1500);
                    e = sb.pop_front();
                    wait_cyc = 0;
                end
            end
            busy_q = busy; done_q = done; wen_q = bus.w_en; ren_q = bus.r_en;
        end
    end

    // Stimulus
    task automatic push_run(input int lat, input bit ps, input bit to, input int err,
                            input int fa, input int wnum, input int rnum);
        exp_t x;
        x.is_rst = 0; x.lat = lat; x.ps = ps; x.to = to;
        x.err = err; x.fa = fa; x.wn = wnum; x.rn = rnum;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        exp_t x;
        x = '{1, 0, 0, 0, 0, 0, 0, 0};
        @(posedge clock); #1;
        sb.push_back(x);
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        repeat (10) @(posedge clock);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1;
        @(posedge clock); #1;
        start = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 4000) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d scoreboard entries outstanding", sb.size());
            $fatal(1, "scoreboard stalled");
        end
    endtask

    task automatic wait_level(input bit want_done);
        int n = 0;
        while ((want_done ? !done : !busy) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) begin
            $display("FAIL wait_level: %s never rose", want_done ? "done" : "busy");
            $fatal(1, "bounded wait expired");
        end
    endtask

    initial begin
        do_reset();

        // Nominal run
        push_run(241, 1, 0, 0, 0, 32, 48);
        pulse_start();
        drain();

        // Bit 0 of word 5 stuck low: only the ~P verify at 5 fails (5E vs 5F)
        do_reset();
        stuck = 1;
        push_run(241, 0, 0, 1, 5, 32, 48);
        pulse_start();
        drain();
        stuck = 0;

        // Slow ports: 1 + 48*4 + 32*5
        do_reset();
        ww = 2; rw = 1;
        push_run(353, 1, 0, 0, 0, 32, 48);
        pulse_start();
        drain();
        ww = 0; rw = 0;

        // Read port never ready: watchdog fires in WAIT_RDY
        do_reset();
        hold_low = 1;
        push_run(255, 0, 1, 0, 0, 0, 0);
        pulse_start();
        drain();
        hold_low = 0;

        // Reset during phase 3 (cycles 145..192), then a clean rerun
        do_reset();
        pulse_start();
        repeat (160) @(posedge clock);
        do_reset();
        push_run(241, 1, 0, 0, 0, 32, 48);
        pulse_start();
        drain();

        // Start pulse while busy is ignored
        do_reset();
        push_run(241, 1, 0, 0, 0, 32, 48);
        pulse_start();
        repeat (50) @(posedge clock);
        pulse_start();
        drain();

        // Start held through DONE: second run sees stale ~P data in phase 0 (16 errors) plus the stuck bit
        do_reset();
        stuck = 1;
        push_run(241, 0, 0, 1, 5, 32, 48);
        push_run(241, 0, 0, 17, 0, 32, 48);
        @(negedge clock);
        start = 1;
        wait_level(1);
        @(negedge clock);
        wait_level(0);
        start = 0;
        drain();
        stuck = 0;

        repeat (5) @(posedge clock);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
